// File: rtl/maxpool_1d_stream.sv
// -----------------------------------------------------------------------------
// maxpool_1d_stream
//
// Streaming 1-D max-pool stage. It consumes a vector of N signed samples over a
// valid/ready handshake and emits floor(N/P) signed maxima, one for each
// non-overlapping window of P samples. Tail samples (N mod P) are accepted and
// dropped, so the upstream producer never stalls on a partial window.
//
// Ports
//   clk      in   single clock, all state changes on the rising edge
//   reset    in   synchronous, active-high
//   x_data   in   W-bit signed input sample
//   x_valid  in   input sample valid
//   x_ready  out  block accepts x_data this cycle (high in ACC and DROP)
//   y_data   out  W-bit signed pooled maximum
//   y_valid  out  y_data valid (high in OUT only)
//   y_ready  in   downstream accepts y_data
// -----------------------------------------------------------------------------
module maxpool_1d_stream #(
  parameter int N = 22,
  parameter int P = 2,
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] x_data,
  input  logic         x_valid,
  output logic         x_ready,
  output logic [W-1:0] y_data,
  output logic         y_valid,
  input  logic         y_ready
);

  localparam int NW = N / P;  // windows per vector
  localparam int NT = N % P;  // tail samples per vector

  localparam int ELEM_W = (P  > 1) ? $clog2(P)  : 1;
  localparam int WIN_W  = (NW > 1) ? $clog2(NW) : 1;
  localparam int TAIL_W = (NT > 1) ? $clog2(NT) : 1;

  localparam logic [ELEM_W-1:0] ELEM_LAST = ELEM_W'(P - 1);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(NW - 1);
  // With no tail the DROP state is never entered, so this value is unused.
  localparam logic [TAIL_W-1:0] TAIL_LAST = TAIL_W'((NT > 0) ? (NT - 1) : 0);

  typedef enum logic [1:0] {
    ST_ACC  = 2'd0,
    ST_OUT  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ELEM_W-1:0]   elem_cnt_q, elem_cnt_d;
  logic [WIN_W-1:0]    win_cnt_q, win_cnt_d;
  logic [TAIL_W-1:0]   tail_cnt_q, tail_cnt_d;
  logic [W-1:0]        max_q, max_d;
  logic [W-1:0]        y_data_q, y_data_d;
  logic [W-1:0]        max_upd;

  // Running maximum including the current sample. The first sample of a
  // window seeds the maximum; afterwards only a strictly larger sample wins,
  // so a tie keeps the stored value.
  always_comb begin
    if ((elem_cnt_q == '0) || ($signed(x_data) > $signed(max_q))) begin
      max_upd = x_data;
    end else begin
      max_upd = max_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    elem_cnt_d = elem_cnt_q;
    win_cnt_d  = win_cnt_q;
    tail_cnt_d = tail_cnt_q;
    max_d      = max_q;
    y_data_d   = y_data_q;

    case (state_q)
      ST_ACC: begin
        if (x_valid) begin
          max_d = max_upd;
          if (elem_cnt_q == ELEM_LAST) begin
            y_data_d   = max_upd;
            elem_cnt_d = '0;
            state_d    = ST_OUT;
          end else begin
            elem_cnt_d = elem_cnt_q + 1'b1;
          end
        end
      end

      ST_OUT: begin
        if (y_ready) begin
          if (win_cnt_q == WIN_LAST) begin
            win_cnt_d = '0;
            state_d   = (NT != 0) ? ST_DROP : ST_ACC;
          end else begin
            win_cnt_d = win_cnt_q + 1'b1;
            state_d   = ST_ACC;
          end
        end
      end

      ST_DROP: begin
        // Tail samples are consumed without touching max or y_data.
        if (x_valid) begin
          if (tail_cnt_q == TAIL_LAST) begin
            tail_cnt_d = '0;
            state_d    = ST_ACC;
          end else begin
            tail_cnt_d = tail_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_ACC;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_ACC;
      elem_cnt_q <= '0;
      win_cnt_q  <= '0;
      tail_cnt_q <= '0;
      max_q      <= '0;
      y_data_q   <= '0;
    end else begin
      state_q    <= state_d;
      elem_cnt_q <= elem_cnt_d;
      win_cnt_q  <= win_cnt_d;
      tail_cnt_q <= tail_cnt_d;
      max_q      <= max_d;
      y_data_q   <= y_data_d;
    end
  end

  // Handshake outputs are decoded purely from the state register.
  assign x_ready = (state_q != ST_OUT);
  assign y_valid = (state_q == ST_OUT);
  assign y_data  = y_data_q;

endmodule

// File: tb/tb_maxpool_1d_stream.sv
// -----------------------------------------------------------------------------
// tb_maxpool_1d_stream
//
// Two instances: index 0 is N=22,P=2 (no tail), index 1 is N=7,P=3 (tail of 1).
// A reference model collects accepted samples per vector and computes window
// maxima with plain arithmetic; every output transfer is compared against it.
// -----------------------------------------------------------------------------
module tb_maxpool_1d_stream;

  localparam int W = 11;
  localparam int NV [2] = '{22, 7};
  localparam int PV [2] = '{2, 3};

  logic         clk;
  logic         reset;
  logic [W-1:0] x_data  [2];
  logic         x_valid [2];
  logic         x_ready [2];
  logic [W-1:0] y_data  [2];
  logic         y_valid [2];
  logic         y_ready [2];

  int n_tests = 0;
  int n_fail  = 0;

  int vec_q  [2][$];  // samples of the vector currently being received
  int exp_q  [2][$];  // expected outputs not yet seen
  int got_q  [2][$];  // observed outputs
  int stim_q [2][$];  // samples still to be sent

  maxpool_1d_stream #(.N(22), .P(2), .W(W)) dut_a (
    .clk     (clk),
    .reset   (reset),
    .x_data  (x_data[0]),
    .x_valid (x_valid[0]),
    .x_ready (x_ready[0]),
    .y_data  (y_data[0]),
    .y_valid (y_valid[0]),
    .y_ready (y_ready[0])
  );

  maxpool_1d_stream #(.N(7), .P(3), .W(W)) dut_b (
    .clk     (clk),
    .reset   (reset),
    .x_data  (x_data[1]),
    .x_valid (x_valid[1]),
    .x_ready (x_ready[1]),
    .y_data  (y_data[1]),
    .y_valid (y_valid[1]),
    .y_ready (y_ready[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sx(logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  task automatic check(string tag, int obs, int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: a vector is N samples; sample k belongs to window k/P; only
  // complete windows below N/P produce an output, the rest is discarded.
  function automatic void model_accept(int i, int v);
    int n;
    int m;
    vec_q[i].push_back(v);
    n = vec_q[i].size();
    if ((n % PV[i] == 0) && (n / PV[i] <= NV[i] / PV[i])) begin
      m = vec_q[i][n - PV[i]];
      for (int k = n - PV[i] + 1; k < n; k++) begin
        if (vec_q[i][k] > m) m = vec_q[i][k];
      end
      exp_q[i].push_back(m);
    end
    if (n == NV[i]) vec_q[i].delete();
  endfunction

  // One clock cycle: snapshot handshake state, advance past the edge, then
  // update model/scoreboard and check hold and latency rules.
  task automatic tick();
    bit rst;
    bit inx  [2];
    bit outx [2];
    bit pyv  [2];
    bit pyr  [2];
    int pyd  [2];
    int xd   [2];
    rst = reset;
    for (int i = 0; i < 2; i++) begin
      inx[i]  = x_valid[i] && x_ready[i];
      outx[i] = y_valid[i] && y_ready[i];
      pyv[i]  = y_valid[i];
      pyr[i]  = y_ready[i];
      pyd[i]  = sx(y_data[i]);
      xd[i]   = sx(x_data[i]);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        vec_q[i].delete();
        exp_q[i].delete();
      end else begin
        if (inx[i]) model_accept(i, xd[i]);
        if (outx[i]) begin
          got_q[i].push_back(pyd[i]);
          if (exp_q[i].size() == 0)
            check($sformatf("unexpected_out%0d", i), pyd[i], -99999);
          else
            check($sformatf("y_data%0d", i), pyd[i], exp_q[i].pop_front());
        end
        if (pyv[i] && !pyr[i]) begin
          check($sformatf("hold_valid%0d", i), int'(y_valid[i]), 1);
          check($sformatf("hold_data%0d", i), sx(y_data[i]), pyd[i]);
        end
        if (!pyv[i] && y_valid[i])
          check($sformatf("valid_latency%0d", i), int'(inx[i]), 1);
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      x_valid[i] = 1'b0;
      y_ready[i] = 1'b0;
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic run_stim(int i, int vpct, int rpct);
    int g;
    bit xf;
    g = 0;
    while (stim_q[i].size() > 0 && g < 20000) begin
      x_valid[i] = ($urandom_range(0, 99) < vpct);
      x_data[i]  = W'(stim_q[i][0]);
      y_ready[i] = ($urandom_range(0, 99) < rpct);
      xf = x_valid[i] && x_ready[i];
      tick();
      if (xf) void'(stim_q[i].pop_front());
      g++;
    end
    x_valid[i] = 1'b0;
    if (g >= 20000) check($sformatf("stim_timeout%0d", i), 0, 1);
  endtask

  task automatic drain(int i);
    int g;
    g = 0;
    x_valid[i] = 1'b0;
    y_ready[i] = 1'b1;
    while ((exp_q[i].size() > 0 || y_valid[i]) && g < 200) begin
      tick();
      g++;
    end
    if (g >= 200) check($sformatf("drain_timeout%0d", i), 0, 1);
  endtask

  task automatic rand_vecs(int i, int nvec);
    for (int k = 0; k < nvec * NV[i]; k++)
      stim_q[i].push_back(int'($urandom_range(0, 2047)) - 1024);
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      x_data[i]  = '0;
      x_valid[i] = 1'b0;
      y_ready[i] = 1'b0;
    end
    tick();
    do_reset();

    // Reset state.
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_x_ready%0d", i), int'(x_ready[i]), 1);
      check($sformatf("rst_y_valid%0d", i), int'(y_valid[i]), 0);
      check($sformatf("rst_y_data%0d", i), sx(y_data[i]), 0);
    end

    // Ramp 0..21, free-flowing output: maxima are the odd values.
    got_q[0].delete();
    for (int v = 0; v < 22; v++) stim_q[0].push_back(v);
    run_stim(0, 100, 100);
    drain(0);
    check("ramp_count", got_q[0].size(), 11);
    for (int k = 0; k < 11 && k < got_q[0].size(); k++)
      check($sformatf("ramp_y%0d", k), got_q[0][k], 2 * k + 1);

    // Signed windows and a tie.
    do_reset();
    got_q[0].delete();
    stim_q[0] = '{-5, -2, -1024, 1023, 4, 4};
    for (int k = 0; k < 16; k++) stim_q[0].push_back(int'($urandom_range(0, 2047)) - 1024);
    run_stim(0, 100, 100);
    drain(0);
    check("signed_count", got_q[0].size(), 11);
    if (got_q[0].size() >= 3) begin
      check("signed_neg", got_q[0][0], -2);
      check("signed_ext", got_q[0][1], 1023);
      check("signed_tie", got_q[0][2], 4);
    end

    // Backpressure: output held for 5 cycles, input ignored meanwhile.
    do_reset();
    got_q[0].delete();
    y_ready[0] = 1'b0;
    x_valid[0] = 1'b1;
    x_data[0]  = W'(7);
    tick();
    x_data[0]  = W'(3);
    tick();
    x_data[0]  = W'(100);
    for (int k = 0; k < 5; k++) begin
      check("bp_y_valid", int'(y_valid[0]), 1);
      check("bp_x_ready", int'(x_ready[0]), 0);
      check("bp_y_data", sx(y_data[0]), 7);
      tick();
    end
    x_valid[0] = 1'b0;
    y_ready[0] = 1'b1;
    tick();
    check("bp_count", got_q[0].size(), 1);
    if (got_q[0].size() >= 1) check("bp_value", got_q[0][0], 7);

    // Tail handling on the N=7,P=3 instance.
    do_reset();
    got_q[1].delete();
    stim_q[1] = '{1, 2, 3, 4, 5, 6, 7, 9, 8, 7, 6, 5, 4, 3};
    run_stim(1, 100, 100);
    drain(1);
    check("tail_count", got_q[1].size(), 4);
    if (got_q[1].size() >= 4) begin
      check("tail_y0", got_q[1][0], 3);
      check("tail_y1", got_q[1][1], 6);
      check("tail_y2", got_q[1][2], 9);
      check("tail_y3", got_q[1][3], 6);
    end

    // Reset mid-window discards the partial maximum.
    do_reset();
    got_q[0].delete();
    x_valid[0] = 1'b1;
    x_data[0]  = W'(50);
    tick();
    reset = 1'b1;
    x_data[0] = W'(77);
    tick();
    check("rstw_y_valid", int'(y_valid[0]), 0);
    check("rstw_x_ready", int'(x_ready[0]), 1);
    reset = 1'b0;
    stim_q[0] = '{2, 1};
    run_stim(0, 100, 100);
    drain(0);
    check("rstw_count", got_q[0].size(), 1);
    if (got_q[0].size() >= 1) check("rstw_value", got_q[0][0], 2);

    // Reset while an output is pending drops it.
    do_reset();
    got_q[0].delete();
    stim_q[0] = '{8, 9};
    run_stim(0, 100, 0);
    y_ready[0] = 1'b0;
    tick();
    check("rsto_pending", int'(y_valid[0]), 1);
    reset = 1'b1;
    tick();
    check("rsto_y_valid", int'(y_valid[0]), 0);
    reset = 1'b0;
    drain(0);
    check("rsto_count", got_q[0].size(), 0);

    // Random gaps over three vectors on both instances.
    do_reset();
    got_q[0].delete();
    got_q[1].delete();
    rand_vecs(0, 3);
    run_stim(0, 60, 60);
    drain(0);
    check("rand_count0", got_q[0].size(), 33);
    rand_vecs(1, 3);
    run_stim(1, 60, 60);
    drain(1);
    check("rand_count1", got_q[1].size(), 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
